// File: rtl/sipo_word_receiver_if.sv
// Bundle of the serial-in and word-out handshake signals of the SIPO word receiver.
// The slave modport is the receiver; the master modport is the bit source and word consumer.
interface sipo_word_receiver_if #(
  parameter int N = 8
);
  localparam int CW = $clog2(N);

  logic          ser_in;
  logic          ser_valid;
  logic          sync;
  logic          dir;
  logic [N-1:0]  word_out;
  logic          word_valid;
  logic          word_ready;
  logic [CW-1:0] bit_cnt;
  logic          overrun;
  logic          ovr_clr;

  modport slave (
    input  ser_in, ser_valid, sync, dir, word_ready, ovr_clr,
    output word_out, word_valid, bit_cnt, overrun
  );

  modport master (
    output ser_in, ser_valid, sync, dir, word_ready, ovr_clr,
    input  word_out, word_valid, bit_cnt, overrun
  );
endinterface

// File: rtl/sipo_word_receiver.sv
// Serial-to-parallel receiver: rebuilds N-bit words MSB- or LSB-first into a
// one-deep valid/ready output buffer, with a sticky overrun flag for dropped words.
module sipo_word_receiver #(
  parameter int N = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  sipo_word_receiver_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [N-1:0]  shreg;
  logic [CW-1:0] bit_cnt;
  logic          dir_q;
  logic [N-1:0]  word_out;
  logic          word_valid;
  logic          overrun;

  logic          dir_eff;
  logic [N-1:0]  base;
  logic [N-1:0]  shifted;
  logic          complete;
  logic          accept_word;
  logic          drop_word;

  // A sync restarts the word from a cleared register, so its bit is bit 0.
  always_comb begin
    dir_eff     = dir_q;
    base        = shreg;
    shifted     = shreg;
    complete    = 1'b0;
    accept_word = 1'b0;
    drop_word   = 1'b0;

    if (bus.sync || bit_cnt == '0)
      dir_eff = bus.dir;
    if (bus.sync)
      base = '0;

    if (dir_eff)
      shifted = {bus.ser_in, base[N-1:1]};
    else
      shifted = {base[N-2:0], bus.ser_in};

    complete    = bus.ser_valid && !bus.sync && (bit_cnt == LAST);
    accept_word = complete && (!word_valid || bus.word_ready);
    drop_word   = complete && word_valid && !bus.word_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      dir_q      <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (bus.ser_valid) begin
        shreg <= shifted;
        if (bus.sync || bit_cnt == '0)
          dir_q <= bus.dir;
      end else if (bus.sync) begin
        shreg <= '0;
      end

      if (bus.sync)
        bit_cnt <= bus.ser_valid ? CW'(1) : '0;
      else if (complete)
        bit_cnt <= '0;
      else if (bus.ser_valid)
        bit_cnt <= bit_cnt + CW'(1);

      if (accept_word) begin
        word_out   <= shifted;
        word_valid <= 1'b1;
      end else if (word_valid && bus.word_ready) begin
        word_valid <= 1'b0;
      end

      // Set beats clear when both land on the same edge.
      if (drop_word)
        overrun <= 1'b1;
      else if (bus.ovr_clr)
        overrun <= 1'b0;
    end
  end

  assign bus.word_out   = word_out;
  assign bus.word_valid = word_valid;
  assign bus.bit_cnt    = bit_cnt;
  assign bus.overrun    = overrun;
endmodule

// File: tb/tb_sipo_word_receiver.sv
// Directed self-checking bench for sipo_word_receiver: bit ordering, handshake,
// overrun, sync restart and asynchronous reset, with hand-computed expectations.
module tb_sipo_word_receiver;
  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sipo_word_receiver_if #(.N(N)) bus ();

  sipo_word_receiver #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic drive_cycle(input logic b, input logic v, input logic s,
                             input logic d, input logic rdy, input logic clr);
    @(negedge clk);
    bus.ser_in     = b;
    bus.ser_valid  = v;
    bus.sync       = s;
    bus.dir        = d;
    bus.word_ready = rdy;
    bus.ovr_clr    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [N-1:0] w, input logic d, input logic rdy);
    for (int i = 0; i < N; i++)
      drive_cycle(d ? w[i] : w[N-1-i], 1'b1, 1'b0, d, rdy, 1'b0);
  endtask

  task automatic idle_cycle(input logic rdy);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.word_out !== 8'h00 || bus.word_valid !== 1'b0 ||
        bus.bit_cnt !== 3'd0 || bus.overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: got out=%h valid=%b cnt=%0d ovr=%b, want 00/0/0/0",
               bus.word_out, bus.word_valid, bus.bit_cnt, bus.overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_msb_first;
    logic [7:0] bits;
    bits = 8'b1011_0010;
    for (int i = 7; i >= 1; i--)
      drive_cycle(bits[i], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.word_valid !== 1'b0 || bus.bit_cnt !== 3'd7) begin
      failures++;
      $display("[TB] FAIL msb_before_last: got valid=%b cnt=%0d, want 0/7",
               bus.word_valid, bus.bit_cnt);
    end
    drive_cycle(bits[0], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 8'hB2 || bus.bit_cnt !== 3'd0) begin
      failures++;
      $display("[TB] FAIL msb_word: got valid=%b out=%h cnt=%0d, want 1/b2/0",
               bus.word_valid, bus.word_out, bus.bit_cnt);
    end
    idle_cycle(1'b1);
    checks++;
    if (bus.word_valid !== 1'b0 || bus.word_out !== 8'hB2) begin
      failures++;
      $display("[TB] FAIL msb_valid_one_cycle: got valid=%b out=%h, want 0/b2",
               bus.word_valid, bus.word_out);
    end
  endtask

  task automatic test_lsb_first;
    logic [7:0] bits;
    bits = 8'b1011_0010;
    for (int i = 7; i >= 0; i--)
      drive_cycle(bits[i], 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 8'h4D) begin
      failures++;
      $display("[TB] FAIL lsb_word: got valid=%b out=%h, want 1/4d",
               bus.word_valid, bus.word_out);
    end
    idle_cycle(1'b1);
    // dir high only for bit 0; later toggles must be ignored.
    for (int i = 7; i >= 0; i--)
      drive_cycle(bits[i], 1'b1, 1'b0, (i == 7) ? 1'b1 : 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 8'h4D) begin
      failures++;
      $display("[TB] FAIL lsb_dir_toggle: got valid=%b out=%h, want 1/4d",
               bus.word_valid, bus.word_out);
    end
    idle_cycle(1'b1);
  endtask

  task automatic test_overrun;
    send_word(8'hA5, 1'b0, 1'b0);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 8'hA5 || bus.overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovr_first_word: got valid=%b out=%h ovr=%b, want 1/a5/0",
               bus.word_valid, bus.word_out, bus.overrun);
    end
    send_word(8'h3C, 1'b0, 1'b0);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 8'hA5 ||
        bus.overrun !== 1'b1 || bus.bit_cnt !== 3'd0) begin
      failures++;
      $display("[TB] FAIL ovr_dropped: got valid=%b out=%h ovr=%b cnt=%0d, want 1/a5/1/0",
               bus.word_valid, bus.word_out, bus.overrun, bus.bit_cnt);
    end
    idle_cycle(1'b0);
    checks++;
    if (bus.overrun !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovr_sticky: got ovr=%b, want 1", bus.overrun);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.overrun !== 1'b0 || bus.word_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovr_clear: got ovr=%b valid=%b, want 0/1",
               bus.overrun, bus.word_valid);
    end
    idle_cycle(1'b1);
    checks++;
    if (bus.word_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovr_drain: got valid=%b, want 0", bus.word_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w;
    send_word(8'h5A, 1'b0, 1'b0);
    w = 8'hC3;
    for (int i = 7; i >= 1; i--)
      drive_cycle(w[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(w[0], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 8'hC3 || bus.overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_reload: got valid=%b out=%h ovr=%b, want 1/c3/0",
               bus.word_valid, bus.word_out, bus.overrun);
    end
    idle_cycle(1'b1);
    checks++;
    if (bus.word_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_drain: got valid=%b, want 0", bus.word_valid);
    end
  endtask

  task automatic test_sync;
    logic [6:0] tail;
    for (int i = 0; i < 5; i++)
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.bit_cnt !== 3'd5) begin
      failures++;
      $display("[TB] FAIL sync_pre_count: got cnt=%0d, want 5", bus.bit_cnt);
    end
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.bit_cnt !== 3'd1 || bus.word_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sync_restart: got cnt=%0d valid=%b, want 1/0",
               bus.bit_cnt, bus.word_valid);
    end
    tail = 7'b010_0110;
    for (int i = 6; i >= 1; i--) begin
      drive_cycle(tail[i], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (bus.word_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL sync_early_word: got valid=%b, want 0", bus.word_valid);
      end
    end
    drive_cycle(tail[0], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 8'hA6) begin
      failures++;
      $display("[TB] FAIL sync_word: got valid=%b out=%h, want 1/a6",
               bus.word_valid, bus.word_out);
    end
    idle_cycle(1'b1);
    for (int i = 0; i < 7; i++)
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.word_valid !== 1'b0 || bus.bit_cnt !== 3'd1) begin
      failures++;
      $display("[TB] FAIL sync_blocks_completion: got valid=%b cnt=%0d, want 0/1",
               bus.word_valid, bus.bit_cnt);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.bit_cnt !== 3'd0) begin
      failures++;
      $display("[TB] FAIL sync_idle_clear: got cnt=%0d, want 0", bus.bit_cnt);
    end
  endtask

  task automatic test_async_reset;
    send_word(8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.bit_cnt !== 3'd4) begin
      failures++;
      $display("[TB] FAIL rst_setup: got valid=%b cnt=%0d, want 1/4",
               bus.word_valid, bus.bit_cnt);
    end
    @(negedge clk);
    bus.ser_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.word_out !== 8'h00 || bus.word_valid !== 1'b0 ||
        bus.bit_cnt !== 3'd0 || bus.overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_async: got out=%h valid=%b cnt=%0d ovr=%b, want 00/0/0/0",
               bus.word_out, bus.word_valid, bus.bit_cnt, bus.overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      drive_cycle((i == 7) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (bus.word_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rst_spurious_word: got valid=%b, want 0", bus.word_valid);
      end
    end
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 8'h81) begin
      failures++;
      $display("[TB] FAIL rst_first_word: got valid=%b out=%h, want 1/81",
               bus.word_valid, bus.word_out);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    bus.ser_in     = 1'b0;
    bus.ser_valid  = 1'b0;
    bus.sync       = 1'b0;
    bus.dir        = 1'b0;
    bus.word_ready = 1'b0;
    bus.ovr_clr    = 1'b0;

    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overrun();
    test_back_to_back();
    test_sync();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
